// File: rtl/table_lookup_arbiter.sv
// Two-requester round-robin front end to a shared constant lookup table.
// Each requester owns a one-deep response slot; a full slot blocks only its owner.

module table_lookup_arbiter_slot #(
  parameter int DEPTH    = 3,
  parameter int VAL_BASE = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_accept,
  input  logic [15:0] i_index,
  input  logic        i_resp_ready,
  output logic        o_resp_valid,
  output logic [16:0] o_resp_data
);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);
  localparam logic [15:0] BASE_W  = 16'(VAL_BASE);
  localparam logic [16:0] NONE_W  = 17'h10000;

  logic        r_valid;
  logic [16:0] r_data;
  logic        w_hit;
  logic [15:0] w_val;

  // Zero-extend rather than truncate so large indices always miss.
  assign w_hit = {16'd0, i_index} < DEPTH_U;
  assign w_val = BASE_W + i_index;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= NONE_W;
    end else if (i_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_hit ? {1'b0, w_val} : NONE_W;
    end else if (r_valid && i_resp_ready) begin
      r_valid <= 1'b0;
      r_data  <= NONE_W;
    end
  end

  assign o_resp_valid = r_valid;
  assign o_resp_data  = r_data;
endmodule

module table_lookup_arbiter #(
  parameter int DEPTH    = 3,
  parameter int VAL_BASE = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid_i,
  input  logic [15:0] req0_index_i,
  output logic        req0_ready,
  output logic        resp0_valid,
  output logic [16:0] resp0_data,
  input  logic        resp0_ready_i,
  input  logic        req1_valid_i,
  input  logic [15:0] req1_index_i,
  output logic        req1_ready,
  output logic        resp1_valid,
  output logic [16:0] resp1_data,
  input  logic        resp1_ready_i,
  output logic [15:0] grant_count
);
  localparam int NUM_REQ = 2;

  logic [NUM_REQ-1:0]       w_req_valid;
  logic [NUM_REQ-1:0][15:0] w_index;
  logic [NUM_REQ-1:0]       w_resp_ready;
  logic [NUM_REQ-1:0]       w_resp_valid;
  logic [NUM_REQ-1:0][16:0] w_resp_data;
  logic [NUM_REQ-1:0]       w_elig;
  logic [NUM_REQ-1:0]       w_gnt;

  logic        r_last_grant;
  logic [15:0] r_grant_count;

  assign w_req_valid  = {req1_valid_i, req0_valid_i};
  assign w_index      = {req1_index_i, req0_index_i};
  assign w_resp_ready = {resp1_ready_i, resp0_ready_i};

  // A requester holding an unconsumed response sits out arbitration.
  assign w_elig = w_req_valid & ~w_resp_valid & {NUM_REQ{~rst}};

  // r_last_grant == 1 means requester 1 won last, so requester 0 wins a tie.
  assign w_gnt[0] = w_elig[0] & (~w_elig[1] | r_last_grant);
  assign w_gnt[1] = w_elig[1] & (~w_elig[0] | ~r_last_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant  <= 1'b1;
      r_grant_count <= 16'd0;
    end else if (|w_gnt) begin
      r_last_grant  <= w_gnt[1];
      r_grant_count <= r_grant_count + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    table_lookup_arbiter_slot #(
      .DEPTH    (DEPTH),
      .VAL_BASE (VAL_BASE)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .i_accept     (w_gnt[g]),
      .i_index      (w_index[g]),
      .i_resp_ready (w_resp_ready[g]),
      .o_resp_valid (w_resp_valid[g]),
      .o_resp_data  (w_resp_data[g])
    );
  end

  assign req0_ready  = w_gnt[0];
  assign req1_ready  = w_gnt[1];
  assign resp0_valid = w_resp_valid[0];
  assign resp1_valid = w_resp_valid[1];
  assign resp0_data  = w_resp_data[0];
  assign resp1_data  = w_resp_data[1];
  assign grant_count = r_grant_count;
endmodule
